// File: rtl/md_stall_controller_pkg.sv
// Shared definitions for the mult/div stall controller.
//
// Holds the instruction field layout, the opcode and ALU-op encodings the
// controller decodes, the controller FSM state encoding and the NOP word.
// Imported by md_stall_controller and instr_field_decode.
package md_stall_controller_pkg;

  // Field positions (LSB) within a 32-bit instruction word; every field is 5 bits.
  localparam int unsigned FIELD_W    = 5;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS_LSB     = 17;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned ALUOP_LSB  = 2;

  // Opcodes.
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  // ALU ops for R-type instructions.
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Word loaded into a latch to turn it into a bubble.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Controller state.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } md_state_e;

  // Extract a 5-bit field starting at bit lsb.
  function automatic logic [4:0] get_field(input logic [31:0] instr, input int unsigned lsb);
    return instr[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Instruction field decoder for the stall controller.
//
// Purely combinational. One copy looks at the F/D latch, another at the D/X
// latch.
//
// Ports:
//   instr    in  32  instruction word
//   is_lw    out 1   load word
//   is_mul   out 1   R-type multiply
//   is_div   out 1   R-type divide
//   reads_rt out 1   instruction sources register rt (R-type except shifts)
//   reads_rd out 1   instruction sources register rd (sw/bne/jr/blt)
//   rs       out 5   rs field
//   rt       out 5   rt field
//   rd       out 5   rd field
module instr_field_decode
  import md_stall_controller_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_lw,
  output logic        is_mul,
  output logic        is_div,
  output logic        reads_rt,
  output logic        reads_rd,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
);

  logic [4:0] opcode;
  logic [4:0] alu_op;
  logic       is_rtype;

  assign opcode   = get_field(instr, OPCODE_LSB);
  assign alu_op   = get_field(instr, ALUOP_LSB);
  assign rd       = get_field(instr, RD_LSB);
  assign rs       = get_field(instr, RS_LSB);
  assign rt       = get_field(instr, RT_LSB);

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_lw    = (opcode == OP_LW);
  assign is_mul   = is_rtype && (alu_op == ALU_MUL);
  assign is_div   = is_rtype && (alu_op == ALU_DIV);

  // Shifts carry a shamt where rt would otherwise be read.
  assign reads_rt = is_rtype && (alu_op != ALU_SLL) && (alu_op != ALU_SRA);

  // These opcodes use the rd slot as a source operand.
  assign reads_rd = (opcode == OP_SW) || (opcode == OP_BNE) ||
                    (opcode == OP_JR) || (opcode == OP_BLT);

  // Shamt and the two low bits play no part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^{instr[11:7], instr[1:0]};

endmodule

// File: rtl/md_stall_controller.sv
// Mult/div sequencer and load-use stall generator for the X stage.
//
// When a mul/div reaches D/X the controller freezes F/D and D/X, bubbles
// X/M, fires a one-cycle start pulse to the multdiv unit and waits for its
// result (or a timeout). On completion it steers the unit's result and
// exception flag into X/M for one cycle. In IDLE it also raises the
// load-use stall the bypass network cannot cover.
//
// Ports:
//   clock             in  1   system clock, rising edge
//   reset             in  1   synchronous, active-high
//   inFD              in  32  instruction in F/D latch
//   inDX              in  32  instruction in D/X latch
//   flush             in  1   branch/jump taken, D/X squashed this cycle
//   multdiv_ready     in  1   unit result valid
//   multdiv_exception in  1   unit overflow/div-by-zero, valid with ready
//   ctrl_MULT         out 1   registered one-cycle multiply start
//   ctrl_DIV          out 1   registered one-cycle divide start
//   stall_fd          out 1   hold PC and F/D latch
//   stall_dx          out 1   hold D/X latch
//   bubble_xm         out 1   load nop into X/M
//   md_result_sel     out 1   X/M takes the multdiv result
//   md_ovf            out 1   exception flag to X/M, valid with md_result_sel
//   md_busy           out 1   controller not idle
module md_stall_controller
  import md_stall_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inFD,
  input  logic [31:0] inDX,
  input  logic        flush,
  input  logic        multdiv_ready,
  input  logic        multdiv_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_xm,
  output logic        md_result_sel,
  output logic        md_ovf,
  output logic        md_busy
);

  // ---------------------------------------------------------------------------
  // Field decode of both latches
  // ---------------------------------------------------------------------------
  logic       fd_is_lw, fd_is_mul, fd_is_div, fd_reads_rt, fd_reads_rd;
  logic [4:0] fd_rs, fd_rt, fd_rd;
  logic       dx_is_lw, dx_is_mul, dx_is_div, dx_reads_rt, dx_reads_rd;
  logic [4:0] dx_rs, dx_rt, dx_rd;

  instr_field_decode u_fd_decode (
    .instr    (inFD),
    .is_lw    (fd_is_lw),
    .is_mul   (fd_is_mul),
    .is_div   (fd_is_div),
    .reads_rt (fd_reads_rt),
    .reads_rd (fd_reads_rd),
    .rs       (fd_rs),
    .rt       (fd_rt),
    .rd       (fd_rd)
  );

  instr_field_decode u_dx_decode (
    .instr    (inDX),
    .is_lw    (dx_is_lw),
    .is_mul   (dx_is_mul),
    .is_div   (dx_is_div),
    .reads_rt (dx_reads_rt),
    .reads_rd (dx_reads_rd),
    .rs       (dx_rs),
    .rt       (dx_rt),
    .rd       (dx_rd)
  );

  // Only the consumer side of F/D and the producer side of D/X matter here.
  logic unused_decode;
  assign unused_decode = ^{fd_is_lw, fd_is_mul, fd_is_div,
                           dx_reads_rt, dx_reads_rd, dx_rs, dx_rt};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic st_idle, st_busy, st_done;
  assign st_idle = (state_q == StIdle);
  assign st_busy = (state_q == StBusy);
  assign st_done = (state_q == StDone);

  // ---------------------------------------------------------------------------
  // Hazard detection (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic dx_is_md;
  logic fd_reads_dx_rd;
  logic start;
  logic load_use;

  assign dx_is_md = dx_is_mul || dx_is_div;

  assign fd_reads_dx_rd = (fd_rs == dx_rd) ||
                          (fd_reads_rt && (fd_rt == dx_rd)) ||
                          (fd_reads_rd && (fd_rd == dx_rd));

  // A squashed D/X instruction neither starts the unit nor stalls anything.
  assign start    = st_idle && !flush && dx_is_md;
  assign load_use = st_idle && !flush && !dx_is_md && dx_is_lw &&
                    (dx_rd != 5'd0) && fd_reads_dx_rd;

  // Busy-cycle bookkeeping: cnt_q counts completed BUSY cycles.
  logic first_busy;
  logic last_busy;
  assign first_busy = (cnt_q == '0);
  assign last_busy  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StBusy;
            cnt_q     <= '0;
            ctrl_MULT <= dx_is_mul;
            ctrl_DIV  <= dx_is_div;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // The pulse cycle cannot carry a valid result; a ready that
          // coincides with the timeout still delivers the real result.
          if (!first_busy && multdiv_ready) begin
            state_q <= StDone;
            ovf_q   <= multdiv_exception;
          end else if (last_busy) begin
            state_q <= StDone;
            ovf_q   <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Stalls are quiet while reset is held, even with a mul/div sitting in D/X.
  assign stall_dx      = !reset && (start || st_busy);
  assign bubble_xm     = stall_dx;
  assign stall_fd      = !reset && (start || st_busy || load_use);
  assign md_result_sel = st_done;
  assign md_ovf        = ovf_q;
  assign md_busy       = !st_idle;

endmodule
